// File: rtl/snake_pkg.sv
// Shared constants for the snake update scheduler: playfield size, segment
// store depth, heading encodings, FSM state encoding and start-of-game
// coordinates.
package snake_pkg;

  localparam int GRID_W  = 40;
  localparam int GRID_H  = 30;
  localparam int MAX_LEN = 64;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_WAIT_TICK = 3'd2;
  localparam logic [2:0] ST_WAIT_VB   = 3'd3;
  localparam logic [2:0] ST_SHIFT     = 3'd4;
  localparam logic [2:0] ST_HEAD      = 3'd5;
  localparam logic [2:0] ST_CHECK     = 3'd6;
  localparam logic [2:0] ST_DEAD      = 3'd7;

  localparam logic [5:0] INIT_HEAD_X = 6'd20;
  localparam logic [4:0] INIT_HEAD_Y = 5'd15;
  localparam logic [5:0] INIT_FOOD_X = 6'd30;
  localparam logic [4:0] INIT_FOOD_Y = 5'd15;
  localparam logic [6:0] INIT_LEN    = 7'd3;

  // Bit 1 of the encoding flips between a heading and its reverse.
  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next-head calculator for the snake scheduler.
// Ports:
//   head_x, head_y : current head cell
//   heading        : current heading
//   dir            : requested heading (a reversal request is ignored)
//   new_heading    : heading actually used for this step
//   next_x, next_y : head cell after the step (current cell if wall_out)
//   wall_out       : the step would leave the playfield
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = snake_pkg::GRID_W,
  parameter int GRID_H = snake_pkg::GRID_H
) (
  input  logic [5:0] head_x,
  input  logic [4:0] head_y,
  input  logic [1:0] heading,
  input  logic [1:0] dir,
  output logic [1:0] new_heading,
  output logic [5:0] next_x,
  output logic [4:0] next_y,
  output logic       wall_out
);

  always_comb begin
    new_heading = (dir == opposite_dir(heading)) ? heading : dir;
    next_x      = head_x;
    next_y      = head_y;
    wall_out    = 1'b0;
    case (new_heading)
      DIR_UP: begin
        if (head_y == 5'd0) wall_out = 1'b1;
        else                next_y   = head_y - 5'd1;
      end
      DIR_RIGHT: begin
        if (head_x == 6'(GRID_W - 1)) wall_out = 1'b1;
        else                          next_x   = head_x + 6'd1;
      end
      DIR_DOWN: begin
        if (head_y == 5'(GRID_H - 1)) wall_out = 1'b1;
        else                          next_y   = head_y + 5'd1;
      end
      default: begin
        if (head_x == 6'd0) wall_out = 1'b1;
        else                next_x   = head_x - 6'd1;
      end
    endcase
  end

endmodule

// File: rtl/snake_update_sched.sv
// Snake game update scheduler. Each move tick is deferred to vertical
// blanking, then the body is shifted one slot down the external segment
// store, a new head is written, and the body is scanned for collisions.
// Ports:
//   CLK_100MHz, Reset      : clock, synchronous active-high reset
//   go, tick, VBlank, dir  : start/restart, move pulse, blanking, heading
//   randX, randY           : free-running random values for food placement
//   seg_raddr/seg_rx/ry    : segment store read port (combinational data)
//   seg_we/waddr/wx/wy     : segment store write port
//   length, food_x/y       : game state
//   busy, game_over        : status
//
// state      | meaning
// INIT       | write the three starting segments, load start state
// IDLE       | wait for go
// WAIT_TICK  | wait for a move tick
// WAIT_VB    | tick taken, wait for vertical blanking
// SHIFT      | copy seg[i-1] -> seg[i], i from top down to 1
// HEAD       | compute and write the new head (or die at the wall)
// CHECK      | compare head against seg[1..length-1], then food check
// DEAD       | frozen until go
module snake_update_sched
  import snake_pkg::*;
#(
  parameter int GRID_W  = snake_pkg::GRID_W,
  parameter int GRID_H  = snake_pkg::GRID_H,
  parameter int MAX_LEN = snake_pkg::MAX_LEN
) (
  input  logic        CLK_100MHz,
  input  logic        Reset,
  input  logic        go,
  input  logic        tick,
  input  logic        VBlank,
  input  logic [1:0]  dir,
  input  logic [10:0] randX,
  input  logic [10:0] randY,
  output logic [5:0]  seg_raddr,
  input  logic [5:0]  seg_rx,
  input  logic [4:0]  seg_ry,
  output logic        seg_we,
  output logic [5:0]  seg_waddr,
  output logic [5:0]  seg_wx,
  output logic [4:0]  seg_wy,
  output logic [6:0]  length,
  output logic [5:0]  food_x,
  output logic [4:0]  food_y,
  output logic        busy,
  output logic        game_over
);

  logic [2:0] state;
  logic [1:0] init_cnt;
  logic [6:0] idx;
  logic       grow_pending;
  logic [1:0] heading;
  logic [5:0] head_x;
  logic [4:0] head_y;

  logic [1:0] nh_heading;
  logic [5:0] nh_x;
  logic [4:0] nh_y;
  logic       nh_wall;

  logic [6:0] shift_top;
  logic       head_hit;
  logic [5:0] rand_fx;
  logic [4:0] rand_fy;
  logic       seg_we_raw;
  logic       unused_rand;

  snake_next_head #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_next_head (
    .head_x      (head_x),
    .head_y      (head_y),
    .heading     (heading),
    .dir         (dir),
    .new_heading (nh_heading),
    .next_x      (nh_x),
    .next_y      (nh_y),
    .wall_out    (nh_wall)
  );

  // A pending growth extends the shift by one slot so the old tail survives.
  assign shift_top = grow_pending ? length : length - 7'd1;
  assign head_hit  = (seg_rx == head_x) && (seg_ry == head_y);

  // Fold out-of-range random values back into the playfield.
  assign rand_fx = (randX[5:0] >= 6'(GRID_W)) ? randX[5:0] - 6'(64 - GRID_W) : randX[5:0];
  assign rand_fy = (randY[4:0] >= 5'(GRID_H)) ? randY[4:0] - 5'(32 - GRID_H) : randY[4:0];

  // Upper random bits are not needed.
  assign unused_rand = ^{randX[10:6], randY[10:5]};

  assign busy      = !(state == ST_IDLE || state == ST_WAIT_TICK || state == ST_DEAD);
  assign game_over = (state == ST_DEAD);

  always_comb begin
    seg_raddr  = 6'd0;
    seg_we_raw = 1'b0;
    seg_waddr  = 6'd0;
    seg_wx     = 6'd0;
    seg_wy     = 5'd0;
    case (state)
      ST_INIT: begin
        seg_we_raw = 1'b1;
        seg_waddr  = {4'b0, init_cnt};
        seg_wx     = INIT_HEAD_X - {4'b0, init_cnt};
        seg_wy     = INIT_HEAD_Y;
      end
      ST_SHIFT: begin
        seg_raddr  = 6'(idx - 7'd1);
        seg_we_raw = 1'b1;
        seg_waddr  = idx[5:0];
        seg_wx     = seg_rx;
        seg_wy     = seg_ry;
      end
      ST_HEAD: begin
        seg_we_raw = !nh_wall;
        seg_wx     = nh_x;
        seg_wy     = nh_y;
      end
      ST_CHECK: seg_raddr = idx[5:0];
      default: ;
    endcase
  end

  // Reset suppresses the store write that the current state would issue.
  assign seg_we = seg_we_raw && !Reset;

  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      state        <= ST_INIT;
      init_cnt     <= 2'd0;
      idx          <= 7'd0;
      length       <= 7'd0;
      food_x       <= 6'd0;
      food_y       <= 5'd0;
      grow_pending <= 1'b0;
      heading      <= DIR_RIGHT;
      head_x       <= 6'd0;
      head_y       <= 5'd0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 2'd1;
          if (init_cnt == 2'd2) begin
            init_cnt     <= 2'd0;
            length       <= INIT_LEN;
            heading      <= DIR_RIGHT;
            head_x       <= INIT_HEAD_X;
            head_y       <= INIT_HEAD_Y;
            food_x       <= INIT_FOOD_X;
            food_y       <= INIT_FOOD_Y;
            grow_pending <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_IDLE:      if (go)     state <= ST_WAIT_TICK;
        ST_WAIT_TICK: if (tick)   state <= ST_WAIT_VB;
        ST_WAIT_VB: begin
          if (VBlank) begin
            idx   <= shift_top;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (idx == 7'd1) begin
            if (grow_pending) begin
              length       <= length + 7'd1;
              grow_pending <= 1'b0;
            end
            state <= ST_HEAD;
          end else begin
            idx <= idx - 7'd1;
          end
        end
        ST_HEAD: begin
          if (nh_wall) begin
            state <= ST_DEAD;
          end else begin
            head_x  <= nh_x;
            head_y  <= nh_y;
            heading <= nh_heading;
            idx     <= 7'd1;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (head_hit) begin
            state <= ST_DEAD;
          end else if (idx == length - 7'd1) begin
            if (head_x == food_x && head_y == food_y) begin
              if (length < 7'(MAX_LEN)) grow_pending <= 1'b1;
              food_x <= rand_fx;
              food_y <= rand_fy;
            end
            state <= ST_WAIT_TICK;
          end else begin
            idx <= idx + 7'd1;
          end
        end
        ST_DEAD: begin
          if (go) begin
            init_cnt <= 2'd0;
            state    <= ST_INIT;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_update_sched.sv
module tb_snake_update_sched;

  logic        CLK_100MHz = 1'b0;
  logic        Reset  = 1'b1;
  logic        go     = 1'b0;
  logic        tick   = 1'b0;
  logic        VBlank = 1'b0;
  logic [1:0]  dir    = 2'b01;
  logic [10:0] randX  = 11'd0;
  logic [10:0] randY  = 11'd0;
  logic [5:0]  seg_raddr, seg_waddr, seg_wx, seg_rx;
  logic [4:0]  seg_ry, seg_wy;
  logic        seg_we;
  logic [6:0]  length;
  logic [5:0]  food_x;
  logic [4:0]  food_y;
  logic        busy, game_over;

  always #5 CLK_100MHz = ~CLK_100MHz;

  // Segment store: synchronous write, combinational read.
  logic [5:0] mem_x [64];
  logic [4:0] mem_y [64];
  always @(posedge CLK_100MHz) begin
    if (seg_we) begin
      mem_x[seg_waddr] <= seg_wx;
      mem_y[seg_waddr] <= seg_wy;
    end
  end
  assign seg_rx = mem_x[seg_raddr];
  assign seg_ry = mem_y[seg_raddr];

  snake_update_sched dut (
    .CLK_100MHz (CLK_100MHz),
    .Reset      (Reset),
    .go         (go),
    .tick       (tick),
    .VBlank     (VBlank),
    .dir        (dir),
    .randX      (randX),
    .randY      (randY),
    .seg_raddr  (seg_raddr),
    .seg_rx     (seg_rx),
    .seg_ry     (seg_ry),
    .seg_we     (seg_we),
    .seg_waddr  (seg_waddr),
    .seg_wx     (seg_wx),
    .seg_wy     (seg_wy),
    .length     (length),
    .food_x     (food_x),
    .food_y     (food_y),
    .busy       (busy),
    .game_over  (game_over)
  );

  typedef struct packed {
    logic         is_step;
    logic [6:0]   len;
    logic [5:0]   fx;
    logic [4:0]   fy;
    logic         over;
    logic [7:0]   lat;
    logic [703:0] body;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int pops   = 0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_len, m_fx, m_fy, m_hd;
  bit m_grow, m_dead;
  int bx[$];
  int by[$];

  function automatic exp_t pack_exp(input bit is_step, input int lat);
    exp_t e;
    e.is_step = is_step;
    e.len     = 7'(m_len);
    e.fx      = 6'(m_fx);
    e.fy      = 5'(m_fy);
    e.over    = m_dead;
    e.lat     = 8'(lat);
    e.body    = '0;
    for (int i = 0; i < bx.size() && i < 64; i++)
      e.body[i*11 +: 11] = {6'(bx[i]), 5'(by[i])};
    return e;
  endfunction

  task automatic model_init();
    bx.delete(); by.delete();
    for (int i = 0; i < 3; i++) begin
      bx.push_back(20 - i);
      by.push_back(15);
    end
    m_len = 3; m_fx = 30; m_fy = 15; m_hd = 1; m_grow = 0; m_dead = 0;
  endtask

  task automatic model_step(input int d, input int rx, input int ry, output exp_t e);
    int top, nl, h, nx, ny, lat, k;
    bit out;
    int nbx[$];
    int nby[$];
    top = m_grow ? m_len : m_len - 1;
    nl  = m_grow ? m_len + 1 : m_len;
    m_grow = 0;
    h = (d == (m_hd + 2) % 4) ? m_hd : d;
    nx = bx[0]; ny = by[0];
    case (h)
      0: ny = ny - 1;
      1: nx = nx + 1;
      2: ny = ny + 1;
      default: nx = nx - 1;
    endcase
    out = (nx < 0) || (nx >= 40) || (ny < 0) || (ny >= 30);
    lat = 2 + top;
    nbx.push_back(out ? bx[0] : nx);
    nby.push_back(out ? by[0] : ny);
    for (int i = 0; i <= nl - 2; i++) begin
      nbx.push_back(bx[i]);
      nby.push_back(by[i]);
    end
    if (out) begin
      m_dead = 1;
    end else begin
      m_hd = h;
      k = 0;
      for (int i = 1; i < nl; i++)
        if (k == 0 && nbx[i] == nx && nby[i] == ny) k = i;
      if (k != 0) begin
        m_dead = 1;
        lat += k;
      end else begin
        lat += nl - 1;
        if (nx == m_fx && ny == m_fy) begin
          if (nl < 64) m_grow = 1;
          m_fx = rx % 64;
          if (m_fx >= 40) m_fx -= 24;
          m_fy = ry % 32;
          if (m_fy >= 30) m_fy -= 2;
        end
      end
    end
    bx = nbx; by = nby; m_len = nl;
    e = pack_exp(1, lat);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit mon_prev_busy = 0;
  bit mon_armed     = 0;
  bit mon_counting  = 0;
  int mon_cnt       = 0;

  initial begin : monitor
    exp_t e;
    int bad;
    forever begin
      @(posedge CLK_100MHz);
      #1;
      if (Reset) begin
        mon_armed    = 0;
        mon_counting = 0;
      end else begin
        if (mon_counting) mon_cnt++;
        if (mon_armed && VBlank) begin
          mon_counting = 1;
          mon_cnt      = 1;
          mon_armed    = 0;
        end
        if (tick) mon_armed = 1;
      end
      if (mon_prev_busy && !busy && !Reset) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("length", int'(length), int'(e.len));
          check("food_x", int'(food_x), int'(e.fx));
          check("food_y", int'(food_y), int'(e.fy));
          check("game_over", int'(game_over), int'(e.over));
          check("head_x", int'(mem_x[0]), int'(e.body[5:0] === e.body[5:0] ? e.body[10:5] : 6'd0));
          bad = 0;
          for (int i = 0; i < int'(e.len); i++)
            if ({mem_x[i], mem_y[i]} != e.body[i*11 +: 11]) bad++;
          check("body_cells_wrong", bad, 0);
          if (e.is_step) check("latency", mon_cnt, int'(e.lat));
        end
        pops++;
        mon_counting = 0;
      end
      mon_prev_busy = busy;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_100MHz);
  endtask

  task automatic wait_pops(input int target, input string what);
    int t = 0;
    while (pops < target && t < 400) begin
      @(negedge CLK_100MHz);
      t++;
    end
    check(what, int'(pops >= target), 1);
  endtask

  task automatic pulse_go();
    @(negedge CLK_100MHz) go = 1'b1;
    @(negedge CLK_100MHz) go = 1'b0;
  endtask

  task automatic do_restart();
    int target;
    model_init();
    exp_q.push_back(pack_exp(0, 0));
    target = pops + 1;
    pulse_go();
    wait_pops(target, "restart_init_done");
    pulse_go();
    cyc(1);
  endtask

  task automatic do_step(input int d, input int rx, input int ry);
    exp_t e;
    int target;
    model_step(d, rx, ry, e);
    exp_q.push_back(e);
    target = pops + 1;
    @(negedge CLK_100MHz);
    dir = 2'(d); randX = 11'(rx); randY = 11'(ry); tick = 1'b1;
    @(negedge CLK_100MHz) tick = 1'b0;
    cyc($urandom_range(0, 3));
    VBlank = 1'b1;
    @(negedge CLK_100MHz) VBlank = 1'b0;
    wait_pops(target, "step_done");
  endtask

  task automatic pick_rand(output int rx, output int ry);
    int s, tx, ty;
    if ($urandom_range(0, 1) == 1) begin
      s  = $urandom_range(1, 4);
      tx = bx[0] + ((m_hd == 1) ? s : (m_hd == 3) ? -s : 0);
      ty = by[0] + ((m_hd == 2) ? s : (m_hd == 0) ? -s : 0);
      if (tx < 0) tx = 0;
      if (tx > 39) tx = 39;
      if (ty < 0) ty = 0;
      if (ty > 29) ty = 29;
      rx = (tx >= 16 && $urandom_range(0, 1) == 1) ? tx + 24 : tx;
      ry = (ty >= 28 && $urandom_range(0, 1) == 1) ? ty + 2 : ty;
      rx = rx | (int'($urandom_range(0, 31)) << 6);
      ry = ry | (int'($urandom_range(0, 63)) << 5);
    end else begin
      rx = $urandom_range(0, 2047);
      ry = $urandom_range(0, 2047);
    end
  endtask

  initial begin : stimulus
    int rx, ry, d, target;

    // Reset state
    Reset = 1'b1;
    cyc(2);
    check("rst_busy", int'(busy), 1);
    check("rst_length", int'(length), 0);
    check("rst_food_x", int'(food_x), 0);
    check("rst_food_y", int'(food_y), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_seg_we", int'(seg_we), 0);
    model_init();
    exp_q.push_back(pack_exp(0, 0));
    Reset = 1'b0;
    wait_pops(1, "first_init_done");
    pulse_go();
    cyc(1);

    // Straight run into the food, two meals, ignored reversal, then a tight loop
    for (int s = 1; s <= 9; s++) do_step(1, $urandom_range(0, 2047), $urandom_range(0, 2047));
    do_step(1, 31, 15);
    do_step(1, 45, 31);
    do_step(3, $urandom_range(0, 2047), $urandom_range(0, 2047));
    do_step(0, 0, 0);
    do_step(3, 0, 0);
    do_step(2, 0, 0);
    check("loop_collision_dead", int'(game_over), 1);

    // Drive straight into the right wall
    do_restart();
    for (int s = 0; s < 25 && !m_dead; s++) do_step(1, $urandom_range(0, 2047), $urandom_range(0, 2047));
    check("wall_dead", int'(game_over), 1);

    // Reset in the middle of SHIFT with a tick alongside
    do_restart();
    @(negedge CLK_100MHz);
    dir = 2'b01; tick = 1'b1;
    @(negedge CLK_100MHz) tick = 1'b0;
    VBlank = 1'b1;
    @(negedge CLK_100MHz) VBlank = 1'b0;
    Reset = 1'b1; tick = 1'b1;
    model_init();
    exp_q.push_back(pack_exp(0, 0));
    target = pops + 1;
    @(negedge CLK_100MHz);
    check("midshift_rst_seg_we", int'(seg_we), 0);
    check("midshift_rst_busy", int'(busy), 1);
    check("midshift_rst_length", int'(length), 0);
    Reset = 1'b0; tick = 1'b0;
    wait_pops(target, "midshift_init_done");
    cyc(8);
    check("after_rst_idle", int'(busy), 0);
    check("after_rst_length", int'(length), 3);
    pulse_go();
    cyc(2);
    VBlank = 1'b1;
    @(negedge CLK_100MHz) VBlank = 1'b0;
    cyc(6);
    check("no_stray_step", int'(busy), 0);

    // Randomised play
    for (int s = 0; s < 120; s++) begin
      if (m_dead) do_restart();
      d = ($urandom_range(0, 9) < 6) ? m_hd : int'($urandom_range(0, 3));
      pick_rand(rx, ry);
      do_step(d, rx, ry);
    end

    cyc(5);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
